lcd1602_freq_formatter: RTL and testbench
=========================================

// Module: lcd1602_freq_formatter
// PURPOSE
//  Character source for the LCD1602 write master in the cymometer. Converts a binary frequency
//  measurement to decimal ASCII with a sequential double-dabble and serves a 32-char frame
//  (line 1 fixed banner, line 2 reading) via char_count/data_display, stepping on each master write.
// PARAMETERS
//  FREQ_W   27           width of freq_value (max displayable 99_999_999 Hz)
//  DIGITS   8            decimal digits shown (fixed 8; layout below assumes it)
// PORTS
//  lcd_clk       in   1        single clock, same clock as the LCD master
//  rst           in   1        asynchronous, active-high reset
//  freq_value    in   FREQ_W   measured frequency, Hz, binary
//  freq_valid    in   1        1-cycle strobe: freq_value is a new measurement
//  lcd_we        in   1        master write strobe (high the cycle before master samples data)
//  char_count    out  5        current character index 0..31 (0-15 line 1, 16-31 line 2)
//  data_display  out  8        ASCII for char_count, combinational from char_count + frame regs
//  busy          out  1        conversion in progress
// BEHAVIOUR
//  Reset (async, rst=1): char_count=0, busy=0, FSM=IDLE, pending=0, shown digits = value 0.
//  Char counter: every posedge with lcd_we==1 -> char_count <= char_count+1, 31 wraps to 0.
//   Master samples data_display on that same edge, so it receives the pre-increment char.
//  Frame map: 0-15 "FREQUENCY METER "; 16-17 ' '; 18-25 digit field MSD..LSD; 26 ' ';
//   27 'H'; 28 'z'; 29-31 ' '.
//  Digit field: leading zeros blanked to ' ' (0x20); LSD always shown, so 0 -> "       0".
//   Digits encoded 0x30+d. Overflow (freq_value > 99_999_999) -> field "OVERFLOW".
//  FSM IDLE -> CONVERT -> DONE -> IDLE:
//   IDLE: freq_valid=1 -> latch freq_value into shift reg, clear 32-bit BCD reg, ovf flag
//    = (freq_value > 99_999_999), bit counter=FREQ_W-1, go CONVERT; busy=1 next cycle.
//   CONVERT: one bit per cycle: each BCD nibble >=5 gets +3, then shift {bcd,bin} left 1.
//    After FREQ_W cycles (counter reaches 0) -> DONE.
//   DONE: copy BCD+ovf to shadow regs, pending<=1, busy<=0, -> IDLE.
//   Latency: freq_valid at edge N -> shadow valid and busy low after edge N+FREQ_W+1.
//   freq_valid while busy=1 is ignored (no queueing, no restart).
//  Tear-free update: shown regs load from shadow only on the edge where lcd_we==1 and
//   char_count==31 and pending==1; pending clears that edge. DONE on that same edge wins:
//   pending stays 1, shown regs load the old shadow, new value shows next frame.
//  Width: BCD reg 4*DIGITS bits; values above 99_999_999 never reach the BCD path shown.
//  Reset mid-conversion: abort, all state to reset values; display returns to "0".
// TESTING
//  1 Reset, run master 32 writes -> chars 0-15 "FREQUENCY METER ", 16-31 "         0 Hz   ".
//  2 freq_valid, freq_value=1_234_567 -> busy 28 cycles; after next 31->0 wrap the
//    digit field is " 1234567"; before that wrap the frame still shows "       0".
//  3 freq_value=100_000_000 -> field "OVERFLOW"; then 99_999_999 -> "99999999".
//  4 Second freq_valid during busy (value 42) ignored -> result of the first value shown only.
//  5 lcd_we held high 33 cycles -> char_count 0..31,0,1; one increment per edge, wrap correct.
//  6 rst pulsed mid-CONVERT (cycle 10) -> busy=0, char_count=0, field "       0" immediately.

Source files
------------

// File: rtl/lcd1602_freq_formatter.sv
// Character source for the LCD1602 write master: sequential double-dabble of a binary
// frequency plus a 32-char frame served by char_count/data_display, one step per master write.
module lcd1602_freq_formatter #(
    parameter int FREQ_W = 27,
    parameter int DIGITS = 8
) (
    input  logic              lcd_clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq_value,
    input  logic              freq_valid,
    input  logic              lcd_we,
    output logic [4:0]        char_count,
    output logic [7:0]        data_display,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam int                CNT_W     = $clog2(FREQ_W);
    localparam logic [FREQ_W-1:0] MAX_SHOWN = FREQ_W'(99_999_999);
    localparam logic [127:0]      BANNER    = "FREQUENCY METER ";
    localparam logic [63:0]       OVF_TEXT  = "OVERFLOW";

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q;
    logic [FREQ_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [BCD_W-1:0]   shadow_bcd_q, shown_bcd_q;
    logic               ovf_q, shadow_ovf_q, shown_ovf_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               busy_q, pending_q;
    logic [4:0]         char_cnt_q;
    logic               frame_wrap;
    logic [DIGITS-1:0]  blank;
    logic               seen_nz;
    int                 pos, fi;

    // Strobes: freq_valid is honoured only in IDLE; lcd_we advances the char index on the
    // same edge the master samples data_display, so the master gets the pre-increment char.
    assign frame_wrap   = lcd_we && (char_cnt_q == 5'd31);
    assign char_count   = char_cnt_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge lcd_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            bit_cnt_q    <= '0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            shadow_bcd_q <= '0;
            shadow_ovf_q <= 1'b0;
            shown_bcd_q  <= '0;
            shown_ovf_q  <= 1'b0;
            char_cnt_q   <= 5'd0;
        end else begin
            if (lcd_we) char_cnt_q <= char_cnt_q + 5'd1;
            case (state_q)
                IDLE: begin
                    if (freq_valid) begin
                        bin_q     <= freq_value;
                        bcd_q     <= '0;
                        ovf_q     <= (freq_value > MAX_SHOWN);
                        bit_cnt_q <= CNT_W'(FREQ_W - 1);
                        busy_q    <= 1'b1;
                        state_q   <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    if (bit_cnt_q == '0) state_q <= DONE;
                    else bit_cnt_q <= bit_cnt_q - 1'b1;
                end
                DONE: begin
                    shadow_bcd_q <= bcd_q;
                    shadow_ovf_q <= ovf_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Frame swap only at the end of line 2; a DONE on that edge keeps pending set.
            if (frame_wrap && pending_q) begin
                shown_bcd_q <= shadow_bcd_q;
                shown_ovf_q <= shadow_ovf_q;
            end
            if (state_q == DONE) pending_q <= 1'b1;
            else if (frame_wrap) pending_q <= 1'b0;
        end
    end

    always_comb begin
        data_display = 8'h20;
        blank        = '0;
        seen_nz      = 1'b0;
        pos          = int'(char_cnt_q);
        fi           = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shown_bcd_q[4*(DIGITS-1-i) +: 4] != 4'd0) seen_nz = 1'b1;
            blank[i] = !seen_nz && (i != DIGITS - 1);
        end
        if (pos < 16) begin
            data_display = BANNER[8*(15-pos) +: 8];
        end else if (pos >= 18 && pos <= 25) begin
            fi = pos - 18;
            if (shown_ovf_q)    data_display = OVF_TEXT[8*(7-fi) +: 8];
            else if (blank[fi]) data_display = 8'h20;
            else data_display = 8'h30 + {4'h0, shown_bcd_q[4*(DIGITS-1-fi) +: 4]};
        end else if (pos == 27) begin
            data_display = 8'h48;
        end else if (pos == 28) begin
            data_display = 8'h7A;
        end
    end

endmodule

// File: tb/tb_lcd1602_freq_formatter.sv
// Bench for lcd1602_freq_formatter: directed steps plus random frequencies, frames checked
// against a string-level model of the 32-char display.
module tb_lcd1602_freq_formatter;

    logic        lcd_clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] freq_value = '0;
    logic        freq_valid = 1'b0;
    logic        lcd_we = 1'b0;
    logic [4:0]  char_count;
    logic [7:0]  data_display;
    logic        busy;
    logic [1:0]  dbg_state;

    lcd1602_freq_formatter dut (
        .lcd_clk(lcd_clk),
        .rst(rst),
        .freq_value(freq_value),
        .freq_valid(freq_valid),
        .lcd_we(lcd_we),
        .char_count(char_count),
        .data_display(data_display),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 lcd_clk = ~lcd_clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          exp_cnt = 0;
    int unsigned shown_v = 0;
    int unsigned pend_v = 0;
    bit          pend = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string line_of(input int unsigned v);
        string fld;
        if (v > 99_999_999) fld = "OVERFLOW";
        else fld = $sformatf("%8d", v);
        return {"FREQUENCY METER ", "  ", fld, " Hz   "};
    endfunction

    task automatic push_chars(input int unsigned v, input int start, input int n);
        string s;
        s = line_of(v);
        for (int k = 0; k < n; k++) exp_q.push_back(s[(start + k) % 32]);
    endtask

    // Holds lcd_we for n edges, optionally strobing freq_valid on write index valid_at.
    task automatic run_writes(input int n, input int valid_at, input int unsigned vval);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge lcd_clk);
            lcd_we     = 1'b1;
            freq_valid = (k == valid_at);
            freq_value = 27'(vval);
            check("char_count", 32'(char_count), 32'(exp_cnt));
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("char[%0d]", exp_cnt), 32'(data_display), 32'(e));
            end
            exp_cnt = (exp_cnt + 1) % 32;
        end
        @(negedge lcd_clk);
        lcd_we     = 1'b0;
        freq_valid = 1'b0;
    endtask

    task automatic frame();
        push_chars(shown_v, 0, 32);
        run_writes(32, -1, 0);
        if (pend) begin
            shown_v = pend_v;
            pend    = 0;
        end
    endtask

    task automatic convert(input int unsigned v, input int extra_at, input int unsigned ev);
        int cyc;
        cyc = 0;
        @(negedge lcd_clk);
        freq_value = 27'(v);
        freq_valid = 1'b1;
        @(negedge lcd_clk);
        freq_valid = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            freq_valid = (cyc == extra_at);
            if (cyc == extra_at) freq_value = 27'(ev);
            @(negedge lcd_clk);
        end
        freq_valid = 1'b0;
        check("busy_cycles", 32'(cyc), 32'd28);
        pend_v = v;
        pend   = 1;
    endtask

    initial begin
        int unsigned v;
        repeat (2) @(negedge lcd_clk);
        check("rst_char_count", 32'(char_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_char0", 32'(data_display), 32'h46);
        rst = 1'b0;

        frame();

        convert(1_234_567, -1, 0);
        frame();
        frame();

        convert(100_000_000, -1, 0);
        frame();
        frame();
        convert(99_999_999, -1, 0);
        frame();
        frame();

        convert(7_654_321, 5, 42);
        frame();
        frame();

        push_chars(shown_v, 0, 33);
        run_writes(33, -1, 0);
        check("held_we_count", 32'(char_count), 32'd1);
        push_chars(shown_v, 1, 31);
        run_writes(31, -1, 0);

        // Conversion completing on the very wrap edge that loads the previous result.
        convert(31_415_926, -1, 0);
        push_chars(shown_v, 0, 32);
        run_writes(32, 3, 2_718_281);
        shown_v = 31_415_926;
        pend_v  = 2_718_281;
        pend    = 1;
        check("busy_after_wrap_done", 32'(busy), 32'd0);
        frame();
        frame();

        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 99_999_999);
                2:       v = $urandom_range(100_000_000, 134_217_727);
                default: v = 10 ** $urandom_range(1, 8) - 1;
            endcase
            convert(v, -1, 0);
            frame();
            frame();
        end

        push_chars(shown_v, 0, 5);
        run_writes(5, -1, 0);
        @(negedge lcd_clk);
        freq_value = 27'd88_888_888;
        freq_valid = 1'b1;
        @(negedge lcd_clk);
        freq_valid = 1'b0;
        repeat (9) @(negedge lcd_clk);
        check("busy_mid_convert", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_char_count", 32'(char_count), 32'd0);
        check("abort_char0", 32'(data_display), 32'h46);
        @(negedge lcd_clk);
        rst     = 1'b0;
        exp_cnt = 0;
        shown_v = 0;
        pend    = 0;
        frame();
        frame();
        check("idle_after_abort", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
